// File: rtl/mdio_target_if.sv
// MDIO pad and register-bank signals of an MDIO management target.
// The slave modport is the target side; the master modport drives the pads and the bank.
interface mdio_target_if;
  logic [4:0]  phy_addr;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  phy_addr,
    input  mdc,
    input  mdio_i,
    input  rd_data,
    output mdio_o,
    output mdio_oe,
    output reg_addr,
    output wr_en,
    output wr_data,
    output rd_req,
    output frame_err,
    output busy
  );

  modport master (
    output phy_addr,
    output mdc,
    output mdio_i,
    output rd_data,
    input  mdio_o,
    input  mdio_oe,
    input  reg_addr,
    input  wr_en,
    input  wr_data,
    input  rd_req,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/mdio_target.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on clk, decodes frames, strobes writes
// into a register bank and serialises read data back onto MDIO.
module mdio_target #(
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter bit          BCAST_EN     = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mdio_target_if.slave bus_io
);

  localparam int unsigned PreW = (PREAMBLE_MIN > 0) ? $clog2(PREAMBLE_MIN + 1) : 1;
  localparam logic [PreW-1:0] PreMin = PreW'(PREAMBLE_MIN);

  typedef enum logic [2:0] {
    StIdle, StSt1, StOp, StPhyad, StRegad, StTa, StData, StSkip
  } state_e;

  state_e          state_q;
  logic            mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic            mdio_s1_q, mdio_s2_q;
  logic [PreW-1:0] pre_cnt_q;
  logic [4:0]      bit_cnt_q;
  logic            op_hi_q;
  logic            op_rd_q;
  logic [3:0]      phy_sh_q;
  logic [3:0]      reg_sh_q;
  logic [15:0]     shift_q;
  logic            mdio_o_q, mdio_oe_q;
  logic [4:0]      reg_addr_q;
  logic            wr_en_q, rd_req_q, frame_err_q, busy_q;
  logic [15:0]     wr_data_q;

  logic       rise;
  logic       sbit;
  logic [4:0] phy_full;
  logic       addr_match;

  always_comb begin
    rise       = mdc_s2_q & ~mdc_s3_q;
    sbit       = mdio_s2_q;
    phy_full   = {phy_sh_q, sbit};
    // Broadcast address 0 only ever qualifies a write.
    addr_match = (phy_full == bus_io.phy_addr) ||
                 (BCAST_EN && (phy_full == 5'd0) && !op_rd_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mdc_s1_q    <= 1'b0;
      mdc_s2_q    <= 1'b0;
      mdc_s3_q    <= 1'b0;
      mdio_s1_q   <= 1'b1;
      mdio_s2_q   <= 1'b1;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= 5'd0;
      op_hi_q     <= 1'b0;
      op_rd_q     <= 1'b0;
      phy_sh_q    <= 4'd0;
      reg_sh_q    <= 4'd0;
      shift_q     <= 16'd0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      reg_addr_q  <= 5'd0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_data_q   <= 16'd0;
    end else begin
      mdc_s1_q    <= bus_io.mdc;
      mdc_s2_q    <= mdc_s1_q;
      mdc_s3_q    <= mdc_s2_q;
      mdio_s1_q   <= bus_io.mdio_i;
      mdio_s2_q   <= mdio_s1_q;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;

      if (rise) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
        unique case (state_q)
          StIdle: begin
            bit_cnt_q <= 5'd1;
            if (sbit) begin
              if (pre_cnt_q != PreMin) pre_cnt_q <= pre_cnt_q + PreW'(1);
            end else if (pre_cnt_q >= PreMin) begin
              state_q <= StSt1;
              busy_q  <= 1'b1;
            end else begin
              pre_cnt_q <= '0;
            end
          end

          StSt1: begin
            if (sbit) begin
              state_q <= StOp;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              pre_cnt_q   <= '0;
            end
          end

          StOp: begin
            if (bit_cnt_q == 5'd2) begin
              op_hi_q <= sbit;
            end else if (op_hi_q != sbit) begin
              op_rd_q <= op_hi_q;
              state_q <= StPhyad;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              pre_cnt_q   <= '0;
            end
          end

          StPhyad: begin
            phy_sh_q <= {phy_sh_q[2:0], sbit};
            if (bit_cnt_q == 5'd8) state_q <= addr_match ? StRegad : StSkip;
          end

          StRegad: begin
            reg_sh_q <= {reg_sh_q[2:0], sbit};
            if (bit_cnt_q == 5'd13) begin
              reg_addr_q <= {reg_sh_q, sbit};
              rd_req_q   <= op_rd_q;
              state_q    <= StTa;
            end
          end

          StTa: begin
            if (bit_cnt_q == 5'd14) begin
              if (op_rd_q) begin
                mdio_oe_q <= 1'b1;
                mdio_o_q  <= 1'b0;
              end
            end else begin
              state_q <= StData;
              if (op_rd_q) begin
                shift_q  <= bus_io.rd_data;
                mdio_o_q <= bus_io.rd_data[15];
              end
            end
          end

          StData: begin
            // While driving, the pad echoes our own value, so it is never sampled.
            if (op_rd_q) begin
              mdio_o_q <= shift_q[14];
              shift_q  <= {shift_q[14:0], 1'b0};
            end else begin
              shift_q <= {shift_q[14:0], sbit};
            end
            if (bit_cnt_q == 5'd31) begin
              if (!op_rd_q) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= {shift_q[14:0], sbit};
              end
              mdio_oe_q <= 1'b0;
              mdio_o_q  <= 1'b1;
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              pre_cnt_q <= '0;
            end
          end

          StSkip: begin
            if (bit_cnt_q == 5'd31) begin
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              pre_cnt_q <= '0;
            end
          end

          default: begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            pre_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus_io.mdio_o    = mdio_o_q;
  assign bus_io.mdio_oe   = mdio_oe_q;
  assign bus_io.reg_addr  = reg_addr_q;
  assign bus_io.wr_en     = wr_en_q;
  assign bus_io.wr_data   = wr_data_q;
  assign bus_io.rd_req    = rd_req_q;
  assign bus_io.frame_err = frame_err_q;
  assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_mdio_target.sv
// Directed bench for mdio_target: a bit-banged MDIO master drives two targets
// (default preamble and preamble suppression) and checks strobes and read data.
module tb_mdio_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc_drv = 1'b0;
  logic        mdio_drv = 1'b1;
  logic        sel_b = 1'b0;
  logic [15:0] rd_val = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;

  mdio_target_if ifa ();
  mdio_target_if ifb ();

  assign ifa.phy_addr = 5'd5;
  assign ifa.mdc      = mdc_drv & ~sel_b;
  assign ifa.mdio_i   = mdio_drv;
  assign ifa.rd_data  = rd_val;
  assign ifb.phy_addr = 5'd5;
  assign ifb.mdc      = mdc_drv & sel_b;
  assign ifb.mdio_i   = mdio_drv;
  assign ifb.rd_data  = rd_val;

  mdio_target #(.PREAMBLE_MIN(32), .BCAST_EN(1'b1)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ifa)
  );

  mdio_target #(.PREAMBLE_MIN(0), .BCAST_EN(1'b1)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ifb)
  );

  always #5 clk = ~clk;

  logic busy_m, oe_m, o_m;
  assign busy_m = sel_b ? ifb.busy : ifa.busy;
  assign oe_m   = sel_b ? ifb.mdio_oe : ifa.mdio_oe;
  assign o_m    = sel_b ? ifb.mdio_o : ifa.mdio_o;

  // Strobe monitors: free-running counts plus the values seen at the last strobe.
  int          wr_a = 0, rd_a = 0, err_a = 0, wr_b = 0;
  logic [4:0]  wr_addr_a = 5'd0, rd_addr_a = 5'd0;
  logic [15:0] wr_data_a = 16'd0, wr_data_b = 16'd0;

  always @(negedge clk) begin
    if (ifa.wr_en) begin
      wr_a      <= wr_a + 1;
      wr_addr_a <= ifa.reg_addr;
      wr_data_a <= ifa.wr_data;
    end
    if (ifa.rd_req) begin
      rd_a      <= rd_a + 1;
      rd_addr_a <= ifa.reg_addr;
    end
    if (ifa.frame_err) err_a <= err_a + 1;
    if (ifb.wr_en) begin
      wr_b      <= wr_b + 1;
      wr_data_b <= ifb.wr_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Per-frame observations gathered by send_frame.
  int          busy_bits, oe_bits;
  logic        oe_any, ta_ok;
  logic [15:0] rdata;
  logic        bit_busy, bit_oe, bit_o;

  // One MDC period of 8 clk: mdio changes with mdc low, oe/o sampled just before mdc rises.
  task automatic mdc_cycle(input logic b);
    mdio_drv = b;
    mdc_drv  = 1'b0;
    bit_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bit_busy = bit_busy | busy_m;
      oe_any   = oe_any | oe_m;
    end
    bit_oe  = oe_m;
    bit_o   = o_m;
    mdc_drv = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bit_busy = bit_busy | busy_m;
      oe_any   = oe_any | oe_m;
    end
  endtask

  task automatic send_frame(input bit clr, input int pre, input logic [1:0] st,
                            input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rga, input logic [15:0] data, input bit rd);
    logic [31:0] fr;
    busy_bits = 0;
    oe_bits   = 0;
    oe_any    = 1'b0;
    ta_ok     = 1'b0;
    rdata     = 16'h0000;
    fr = rd ? {st, op, phy, rga, 18'h3FFFF} : {st, op, phy, rga, 2'b10, data};
    if (clr) mdc_cycle(1'b0);
    for (int i = 0; i < pre; i++) begin
      mdc_cycle(1'b1);
      busy_bits += int'(bit_busy);
      oe_bits   += int'(bit_oe);
    end
    for (int k = 0; k < 32; k++) begin
      mdc_cycle(fr[31-k]);
      busy_bits += int'(bit_busy);
      oe_bits   += int'(bit_oe);
      if (k == 15) ta_ok = bit_oe & ~bit_o;
      if (k >= 16) rdata[31-k] = bit_o;
    end
    for (int i = 0; i < 2; i++) begin
      mdc_cycle(1'b1);
      busy_bits += int'(bit_busy);
      oe_bits   += int'(bit_oe);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ifa.mdio_oe !== 1'b0) begin n_bad++;
      $display("FAIL reset_oe: got %b want 0", ifa.mdio_oe); end
    n_cmp++; if (ifa.mdio_o !== 1'b1) begin n_bad++;
      $display("FAIL reset_o: got %b want 1", ifa.mdio_o); end
    n_cmp++; if ({ifa.wr_en, ifa.rd_req, ifa.frame_err, ifa.busy} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_strobes: got %b want 0000",
               {ifa.wr_en, ifa.rd_req, ifa.frame_err, ifa.busy}); end
    n_cmp++; if (ifa.reg_addr !== 5'd0) begin n_bad++;
      $display("FAIL reset_reg_addr: got %h want 00", ifa.reg_addr); end
    n_cmp++; if (ifa.wr_data !== 16'h0000) begin n_bad++;
      $display("FAIL reset_wr_data: got %h want 0000", ifa.wr_data); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (ifa.busy !== 1'b0 || ifa.mdio_oe !== 1'b0) begin n_bad++;
      $display("FAIL post_reset_idle: got busy %b oe %b want 0 0", ifa.busy, ifa.mdio_oe); end
  endtask

  task automatic test_write();
    int w0 = wr_a, e0 = err_a;
    send_frame(1'b1, 32, 2'b01, 2'b01, 5'd5, 5'd3, 16'hA5C3, 1'b0);
    n_cmp++; if (wr_a - w0 !== 1) begin n_bad++;
      $display("FAIL write_count: got %0d want 1", wr_a - w0); end
    n_cmp++; if (wr_addr_a !== 5'd3) begin n_bad++;
      $display("FAIL write_addr: got %h want 03", wr_addr_a); end
    n_cmp++; if (wr_data_a !== 16'hA5C3) begin n_bad++;
      $display("FAIL write_data: got %h want a5c3", wr_data_a); end
    n_cmp++; if (oe_any !== 1'b0) begin n_bad++;
      $display("FAIL write_no_drive: got %b want 0", oe_any); end
    n_cmp++; if (busy_bits !== 32) begin n_bad++;
      $display("FAIL write_busy_bits: got %0d want 32", busy_bits); end
    n_cmp++; if (err_a !== e0) begin n_bad++;
      $display("FAIL write_no_err: got %0d want %0d", err_a, e0); end
  endtask

  task automatic test_read();
    int r0 = rd_a;
    rd_val = 16'h1234;
    send_frame(1'b1, 32, 2'b01, 2'b10, 5'd5, 5'd7, 16'h0000, 1'b1);
    n_cmp++; if (rd_a - r0 !== 1) begin n_bad++;
      $display("FAIL read_req_count: got %0d want 1", rd_a - r0); end
    n_cmp++; if (rd_addr_a !== 5'd7) begin n_bad++;
      $display("FAIL read_req_addr: got %h want 07", rd_addr_a); end
    n_cmp++; if (oe_bits !== 17) begin n_bad++;
      $display("FAIL read_oe_bits: got %0d want 17", oe_bits); end
    n_cmp++; if (ta_ok !== 1'b1) begin n_bad++;
      $display("FAIL read_ta_zero: got %b want 1", ta_ok); end
    n_cmp++; if (rdata !== 16'h1234) begin n_bad++;
      $display("FAIL read_data: got %h want 1234", rdata); end
    n_cmp++; if (ifa.mdio_oe !== 1'b0) begin n_bad++;
      $display("FAIL read_release: got %b want 0", ifa.mdio_oe); end
  endtask

  task automatic test_preamble();
    int w0 = wr_a, e0 = err_a, wb0 = wr_b;
    send_frame(1'b1, 31, 2'b01, 2'b01, 5'd5, 5'd3, 16'h1111, 1'b0);
    n_cmp++; if (wr_a !== w0 || oe_any !== 1'b0 || busy_bits !== 0) begin n_bad++;
      $display("FAIL pre31_ignored: got wr %0d oe %b busy %0d want 0 0 0",
               wr_a - w0, oe_any, busy_bits); end
    n_cmp++; if (err_a !== e0) begin n_bad++;
      $display("FAIL pre31_no_err: got %0d want %0d", err_a, e0); end
    send_frame(1'b1, 32, 2'b01, 2'b01, 5'd5, 5'd3, 16'h2222, 1'b0);
    n_cmp++; if (wr_a - w0 !== 1 || wr_data_a !== 16'h2222) begin n_bad++;
      $display("FAIL pre32_accept: got cnt %0d data %h want 1 2222", wr_a - w0, wr_data_a); end
    sel_b = 1'b1;
    send_frame(1'b0, 0, 2'b01, 2'b01, 5'd5, 5'd9, 16'h5A5A, 1'b0);
    sel_b = 1'b0;
    n_cmp++; if (wr_b - wb0 !== 1 || wr_data_b !== 16'h5A5A) begin n_bad++;
      $display("FAIL pre0_accept: got cnt %0d data %h want 1 5a5a", wr_b - wb0, wr_data_b); end
  endtask

  task automatic test_addr_filter();
    int w0 = wr_a, e0 = err_a, r0 = rd_a;
    send_frame(1'b1, 32, 2'b01, 2'b01, 5'd6, 5'd3, 16'hDEAD, 1'b0);
    n_cmp++; if (wr_a !== w0 || err_a !== e0 || oe_any !== 1'b0) begin n_bad++;
      $display("FAIL other_phy: got wr %0d err %0d oe %b want 0 0 0",
               wr_a - w0, err_a - e0, oe_any); end
    send_frame(1'b1, 32, 2'b01, 2'b01, 5'd0, 5'd1, 16'h00FF, 1'b0);
    n_cmp++; if (wr_a - w0 !== 1 || wr_data_a !== 16'h00FF || wr_addr_a !== 5'd1) begin n_bad++;
      $display("FAIL bcast_write: got cnt %0d data %h addr %h want 1 00ff 01",
               wr_a - w0, wr_data_a, wr_addr_a); end
    send_frame(1'b1, 32, 2'b01, 2'b10, 5'd0, 5'd1, 16'h0000, 1'b1);
    n_cmp++; if (rd_a !== r0 || oe_any !== 1'b0) begin n_bad++;
      $display("FAIL bcast_read: got rd %0d oe %b want 0 0", rd_a - r0, oe_any); end
  endtask

  task automatic test_errors();
    int w0 = wr_a, e0 = err_a;
    send_frame(1'b1, 32, 2'b01, 2'b11, 5'd5, 5'd3, 16'hFFFF, 1'b0);
    n_cmp++; if (err_a - e0 !== 1 || wr_a !== w0) begin n_bad++;
      $display("FAIL op11_err: got err %0d wr %0d want 1 0", err_a - e0, wr_a - w0); end
    send_frame(1'b1, 32, 2'b00, 2'b01, 5'd5, 5'd3, 16'hFFFF, 1'b0);
    n_cmp++; if (err_a - e0 !== 2 || wr_a !== w0) begin n_bad++;
      $display("FAIL st00_err: got err %0d wr %0d want 2 0", err_a - e0, wr_a - w0); end
    send_frame(1'b1, 32, 2'b01, 2'b01, 5'd5, 5'd4, 16'h1357, 1'b0);
    n_cmp++; if (wr_a - w0 !== 1 || wr_data_a !== 16'h1357 || err_a - e0 !== 2) begin n_bad++;
      $display("FAIL recover_write: got cnt %0d data %h err %0d want 1 1357 2",
               wr_a - w0, wr_data_a, err_a - e0); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] fr;
    int r0;
    fr = {2'b01, 2'b10, 5'd5, 5'd7, 18'h3FFFF};
    rd_val = 16'hFFFF;
    oe_any = 1'b0;
    mdc_cycle(1'b0);
    for (int i = 0; i < 32; i++) mdc_cycle(1'b1);
    // After rise 22 the target is driving data bit 8.
    for (int k = 0; k <= 22; k++) mdc_cycle(fr[31-k]);
    n_cmp++; if (ifa.mdio_oe !== 1'b1) begin n_bad++;
      $display("FAIL mid_read_driving: got %b want 1", ifa.mdio_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifa.mdio_oe !== 1'b0 || ifa.busy !== 1'b0) begin n_bad++;
      $display("FAIL mid_read_reset: got oe %b busy %b want 0 0", ifa.mdio_oe, ifa.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    r0 = rd_a;
    rd_val = 16'hC0DE;
    send_frame(1'b1, 32, 2'b01, 2'b10, 5'd5, 5'd2, 16'h0000, 1'b1);
    n_cmp++; if (rdata !== 16'hC0DE || rd_a - r0 !== 1 || oe_bits !== 17) begin n_bad++;
      $display("FAIL read_after_reset: got data %h req %0d oe %0d want c0de 1 17",
               rdata, rd_a - r0, oe_bits); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_preamble();
    test_addr_filter();
    test_errors();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
